run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of retired PC/instruction.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle and instret counters.
REQ-003 SHALL have parameter MAX_CYCLES, default 100, cycle budget before timeout (1..2^CNT_W-1).
REQ-004 SHALL have parameter LOOP_REPEAT, default 4, consecutive same-PC retirements declaring a self-loop halt (>=2).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  pulse; IDLE->RUN.
REQ-008 clear  in  1  pulse; DONE->IDLE, zeroes counters.
REQ-009 step_mode  in  1  1 = single-step, 0 = free-run.
REQ-010 step  in  1  pulse; grants one core cycle in step mode.
REQ-011 retire_valid  in  1  writeback stage retired an instruction this cycle.
REQ-012 retire_pc  in  XLEN  PC of retired instruction.
REQ-013 retire_instr  in  XLEN  encoding of retired instruction.
REQ-014 core_en  out  1  pipeline advance enable.
REQ-015 cycle_count  out  CNT_W  enabled cycles since start.
REQ-016 instret_count  out  CNT_W  retirements since start.
REQ-017 done  out  1  high in DONE.
REQ-018 status  out  2  0 RUNNING, 1 HALT_ECALL, 2 HALT_LOOP, 3 TIMEOUT.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on halt condition; DONE->IDLE on clear; start ignored outside IDLE, clear ignored outside DONE.
REQ-020 In RUN with step_mode=0, core_en SHALL be 1 every cycle; in IDLE and DONE core_en SHALL be 0.
REQ-021 In RUN with step_mode=1, core_en SHALL be 1 for exactly the cycle after each step pulse; step held high SHALL yield one core_en cycle per step rising edge.
REQ-022 cycle_count SHALL increment on each cycle core_en=1, saturating at all-ones.
REQ-023 instret_count SHALL increment on each cycle retire_valid=1 while core_en=1, saturating at all-ones; retire_valid with core_en=0 SHALL be ignored.
REQ-024 ECALL halt: qualified retirement with retire_instr==0x00000073 or 0x00100073 (EBREAK) SHALL move to DONE next cycle, status=1.
REQ-025 Loop halt: qualified retirement whose retire_pc equals the previous qualified retirement's PC increments a repeat counter, else counter resets to 1; reaching LOOP_REPEAT SHALL move to DONE, status=2.
REQ-026 Timeout: core_en cycle in which cycle_count==MAX_CYCLES-1 SHALL move to DONE, status=3; final cycle_count = MAX_CYCLES.
REQ-027 Simultaneous halt conditions SHALL resolve ECALL > LOOP > TIMEOUT.
REQ-028 The halting retirement SHALL be counted in instret_count; core_en SHALL be 0 from the cycle after the halt decision.
REQ-029 status and counters SHALL hold in DONE until clear; clear zeroes counters, repeat counter, status.
REQ-030 start in IDLE SHALL zero counters and repeat counter on the same edge.
REQ-031 step_mode change mid-RUN SHALL take effect next cycle without losing a pending step grant.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, core_en=0, done=0, status=0, both counters 0, repeat counter 0, last-PC 0, step edge detector 0; reset mid-RUN abandons the run.

Structure
REQ-033 Shared package SHALL hold state encoding, status codes, ECALL/EBREAK encodings.
REQ-034 One sub-module run_sat_counter (parametrised width, enable, clear, saturation) SHALL implement both counters.

Verification
REQ-035 start, free-run, retire ECALL at cycle 10 -> done=1, status=1, cycle_count=10, instret as driven, core_en=0 after.
REQ-036 retire PC 0x40 four times consecutively -> status=2 on 4th; 3 repeats then 0x44 -> still RUNNING.
REQ-037 no halt, MAX_CYCLES=100 -> status=3, cycle_count=100 exactly, core_en low cycle 101.
REQ-038 step_mode=1, 5 step pulses with 3-cycle gaps -> exactly 5 core_en cycles, cycle_count=5.
REQ-039 same-cycle ECALL at loop threshold and timeout -> status=1; then clear -> IDLE, counters 0.
REQ-040 rst_n low mid-RUN between edges -> outputs reset immediately; start after release -> fresh run from 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encoding, halt status
// codes and the system-instruction encodings that stop a run.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } run_state_e;

    localparam logic [1:0] STATUS_RUNNING    = 2'd0;
    localparam logic [1:0] STATUS_HALT_ECALL = 2'd1;
    localparam logic [1:0] STATUS_HALT_LOOP  = 2'd2;
    localparam logic [1:0] STATUS_TIMEOUT    = 2'd3;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/run_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module run_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: gates the core pipeline (free-run or single-step), counts
// enabled cycles and retirements, and halts on ECALL/EBREAK, a self-loop or
// the cycle budget. All outputs are registered.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 100,
    parameter int LOOP_REPEAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             step_mode,
    input  logic             step,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [XLEN-1:0]  retire_instr,
    output logic             core_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
    output logic             done,
    output logic [1:0]       status
);

    localparam int                REP_W      = $clog2(LOOP_REPEAT + 1);
    localparam logic [REP_W-1:0]  REP_LIMIT  = REP_W'(LOOP_REPEAT);
    localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    run_state_e       state_q, state_d;
    logic             core_en_q, core_en_d;
    logic             done_q, done_d;
    logic [1:0]       status_q, status_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic             step_prev_q, step_prev_d;

    logic             cnt_clr;
    logic             qual_retire;
    logic             sys_hit;
    logic             loop_hit;
    logic             timeout_hit;
    logic             step_rise;

    // A retirement only counts when the pipeline was actually enabled.
    assign qual_retire = core_en_q && retire_valid;
    assign step_rise   = step && !step_prev_q;
    assign sys_hit     = qual_retire && ((retire_instr == XLEN'(INSTR_ECALL)) ||
                                         (retire_instr == XLEN'(INSTR_EBREAK)));
    assign timeout_hit = core_en_q && (cycle_count == LAST_CYCLE);

    // Next-state and registered-output logic; halt priority ECALL > LOOP > TIMEOUT.
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        rep_d       = rep_q;
        last_pc_d   = last_pc_q;
        step_prev_d = step;
        cnt_clr     = 1'b0;
        loop_hit    = 1'b0;

        // rep_q == 0 marks "no previous retirement in this run".
        if (qual_retire) begin
            last_pc_d = retire_pc;
            if ((rep_q != '0) && (retire_pc == last_pc_q)) begin
                rep_d = rep_q + REP_W'(1);
            end else begin
                rep_d = REP_W'(1);
            end
            loop_hit = (rep_d == REP_LIMIT);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_clr  = 1'b1;
                    rep_d    = '0;
                    status_d = STATUS_RUNNING;
                end
            end
            S_RUN: begin
                if (sys_hit) begin
                    state_d  = S_DONE;
                    status_d = STATUS_HALT_ECALL;
                end else if (loop_hit) begin
                    state_d  = S_DONE;
                    status_d = STATUS_HALT_LOOP;
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    status_d = STATUS_TIMEOUT;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    cnt_clr  = 1'b1;
                    rep_d    = '0;
                    status_d = STATUS_RUNNING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Enable is registered: a step edge sampled now grants the next cycle.
        core_en_d = (state_d == S_RUN) && (!step_mode || step_rise);
        done_d    = (state_d == S_DONE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            core_en_q   <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= STATUS_RUNNING;
            rep_q       <= '0;
            last_pc_q   <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_en_q   <= core_en_d;
            done_q      <= done_d;
            status_q    <= status_d;
            rep_q       <= rep_d;
            last_pc_q   <= last_pc_d;
            step_prev_q <= step_prev_d;
        end
    end

    run_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (core_en_q),
        .clr   (cnt_clr),
        .count (cycle_count)
    );

    run_sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (qual_retire),
        .clr   (cnt_clr),
        .count (instret_count)
    );

    assign core_en = core_en_q;
    assign done    = done_q;
    assign status  = status_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with default parameters (MAX_CYCLES=100,
// LOOP_REPEAT=4). Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic        step_mode;
    logic        step;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic        core_en;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    logic        done;
    logic [1:0]  status;

    int errors = 0;
    int checks = 0;

    run_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .clear         (clear),
        .step_mode     (step_mode),
        .step          (step),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .retire_instr  (retire_instr),
        .core_en       (core_en),
        .cycle_count   (cycle_count),
        .instret_count (instret_count),
        .done          (done),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_retire(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        retire_valid = v;
        retire_pc    = pc;
        retire_instr = instr;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; clear = 1'b0; step_mode = 1'b0; step = 1'b0;
        set_retire(1'b0, 32'h0, 32'h0);
        #12;
        checks++;
        if ({core_en, done, status} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: core_en/done/status=%b expected 0000", {core_en, done, status});
        end
        checks++;
        if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: cycle=%0d instret=%0d expected 0/0", cycle_count, instret_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ecall();
        do_start();
        for (int k = 1; k <= 10; k++) begin
            set_retire(1'b0, 32'h0, 32'h0);
            clear = 1'b0;
            if (k == 3) set_retire(1'b1, 32'h10, 32'h13);
            if (k == 5) begin
                set_retire(1'b1, 32'h14, 32'h13);
                clear = 1'b1;
            end
            if (k == 10) set_retire(1'b1, 32'h20, 32'h0000_0073);
            tick();
            if (k == 5) begin
                checks++;
                if (cycle_count !== 32'd5 || done !== 1'b0 || core_en !== 1'b1) begin
                    errors++;
                    $display("FAIL ecall_clear_ignored: cycle=%0d done=%b core_en=%b expected 5/0/1",
                             cycle_count, done, core_en);
                end
            end
        end
        set_retire(1'b0, 32'h0, 32'h0);
        clear = 1'b0;
        checks++;
        if (done !== 1'b1 || status !== 2'd1 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL ecall_halt: done=%b status=%0d core_en=%b expected 1/1/0", done, status, core_en);
        end
        checks++;
        if (cycle_count !== 32'd10 || instret_count !== 32'd3) begin
            errors++;
            $display("FAIL ecall_counts: cycle=%0d instret=%0d expected 10/3", cycle_count, instret_count);
        end
        // In DONE: start and unqualified retirements must be ignored.
        start = 1'b1;
        set_retire(1'b1, 32'h20, 32'h0000_0073);
        tick();
        start = 1'b0;
        set_retire(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (done !== 1'b1 || core_en !== 1'b0 || instret_count !== 32'd3 || cycle_count !== 32'd10) begin
            errors++;
            $display("FAIL done_hold: done=%b core_en=%b instret=%0d cycle=%0d expected 1/0/3/10",
                     done, core_en, instret_count, cycle_count);
        end
    endtask

    task automatic test_clear();
        do_clear();
        checks++;
        if (done !== 1'b0 || status !== 2'd0 || core_en !== 1'b0 ||
            cycle_count !== 32'd0 || instret_count !== 32'd0) begin
            errors++;
            $display("FAIL clear: done=%b status=%0d core_en=%b cycle=%0d instret=%0d expected 0/0/0/0/0",
                     done, status, core_en, cycle_count, instret_count);
        end
    endtask

    task automatic test_loop();
        logic [31:0] pcs [8];
        pcs = '{32'h40, 32'h40, 32'h40, 32'h44, 32'h40, 32'h40, 32'h40, 32'h40};
        do_start();
        for (int k = 0; k < 8; k++) begin
            set_retire(1'b1, pcs[k], 32'h13);
            tick();
            if (k == 3 || k == 6) begin
                checks++;
                if (done !== 1'b0 || status !== 2'd0) begin
                    errors++;
                    $display("FAIL loop_not_yet_%0d: done=%b status=%0d expected 0/0", k, done, status);
                end
            end
        end
        set_retire(1'b0, 32'h0, 32'h0);
        checks++;
        if (done !== 1'b1 || status !== 2'd2 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL loop_halt: done=%b status=%0d core_en=%b expected 1/2/0", done, status, core_en);
        end
        checks++;
        if (cycle_count !== 32'd8 || instret_count !== 32'd8) begin
            errors++;
            $display("FAIL loop_counts: cycle=%0d instret=%0d expected 8/8", cycle_count, instret_count);
        end
    endtask

    task automatic test_timeout();
        do_clear();
        do_start();
        repeat (99) tick();
        checks++;
        if (cycle_count !== 32'd99 || done !== 1'b0 || core_en !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pre: cycle=%0d done=%b core_en=%b expected 99/0/1", cycle_count, done, core_en);
        end
        tick();
        checks++;
        if (cycle_count !== 32'd100 || done !== 1'b1 || status !== 2'd3 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_halt: cycle=%0d done=%b status=%0d core_en=%b expected 100/1/3/0",
                     cycle_count, done, status, core_en);
        end
        tick();
        checks++;
        if (cycle_count !== 32'd100 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: cycle=%0d core_en=%b expected 100/0", cycle_count, core_en);
        end
    endtask

    task automatic test_step();
        int en_seen;
        do_clear();
        step_mode = 1'b1;
        do_start();
        checks++;
        if (core_en !== 1'b0) begin
            errors++;
            $display("FAIL step_idle_after_start: core_en=%b expected 0", core_en);
        end
        en_seen = 0;
        for (int p = 0; p < 5; p++) begin
            step = 1'b1;
            tick();
            en_seen += int'(core_en);
            step = 1'b0;
            repeat (3) begin
                tick();
                en_seen += int'(core_en);
            end
        end
        checks++;
        if (en_seen !== 5 || cycle_count !== 32'd5) begin
            errors++;
            $display("FAIL step_pulses: en_cycles=%0d cycle=%0d expected 5/5", en_seen, cycle_count);
        end
        en_seen = 0;
        step = 1'b1;
        repeat (4) begin
            tick();
            en_seen += int'(core_en);
        end
        step = 1'b0;
        tick();
        en_seen += int'(core_en);
        checks++;
        if (en_seen !== 1 || cycle_count !== 32'd6) begin
            errors++;
            $display("FAIL step_held: en_cycles=%0d cycle=%0d expected 1/6", en_seen, cycle_count);
        end
        step_mode = 1'b0;
        tick();
        checks++;
        if (core_en !== 1'b1) begin
            errors++;
            $display("FAIL step_mode_switch: core_en=%b expected 1", core_en);
        end
        set_retire(1'b1, 32'h100, 32'h0010_0073);
        tick();
        set_retire(1'b0, 32'h0, 32'h0);
        checks++;
        if (done !== 1'b1 || status !== 2'd1 || cycle_count !== 32'd7 || instret_count !== 32'd1) begin
            errors++;
            $display("FAIL ebreak_halt: done=%b status=%0d cycle=%0d instret=%0d expected 1/1/7/1",
                     done, status, cycle_count, instret_count);
        end
    endtask

    task automatic test_priority();
        do_clear();
        do_start();
        for (int k = 1; k <= 100; k++) begin
            if (k >= 97) set_retire(1'b1, 32'h80, (k == 100) ? 32'h0000_0073 : 32'h13);
            else         set_retire(1'b0, 32'h0, 32'h0);
            tick();
            if (k == 99) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_early: done=%b expected 0 at cycle 99", done);
                end
            end
        end
        set_retire(1'b0, 32'h0, 32'h0);
        checks++;
        if (status !== 2'd1 || done !== 1'b1 || cycle_count !== 32'd100 || instret_count !== 32'd4) begin
            errors++;
            $display("FAIL prio_ecall: status=%0d done=%b cycle=%0d instret=%0d expected 1/1/100/4",
                     status, done, cycle_count, instret_count);
        end
        test_clear();
    endtask

    task automatic test_reset_mid_run();
        do_start();
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({core_en, done, status} !== 4'b0000 || cycle_count !== 32'd0 || instret_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: core_en/done/status=%b cycle=%0d instret=%0d expected 0000/0/0",
                     {core_en, done, status}, cycle_count, instret_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (core_en !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_idle: core_en=%b cycle=%0d expected 0/0", core_en, cycle_count);
        end
        do_start();
        repeat (3) tick();
        checks++;
        if (core_en !== 1'b1 || cycle_count !== 32'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL fresh_run: core_en=%b cycle=%0d done=%b expected 1/3/0", core_en, cycle_count, done);
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_clear();
        test_loop();
        test_timeout();
        test_step();
        test_priority();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
